// File: rtl/stepper_vref_pwm.sv
// Multi-channel stepper Vref PWM: per-channel duty = current x microstep, double-buffered to period boundaries.
// vref is registered 1 clk after the counter/active-duty state; update is accepted in every cycle.
module stepper_vref_pwm #(
    parameter int NCHAN         = 2,
    parameter int CURRENTBITS   = 3,
    parameter int MICROSTEPBITS = 6,
    parameter int PRESCALE      = 1,
    parameter int CENTER        = 0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic [NCHAN*CURRENTBITS-1:0]   current,
    input  logic [NCHAN*MICROSTEPBITS-1:0] microstep,
    input  logic                           update,
    output logic                           pending,
    output logic                           period_start,
    output logic [NCHAN-1:0]               vref
);
    localparam int PWMBITS = CURRENTBITS + MICROSTEPBITS;
    localparam int PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWMBITS-1:0] MAX     = '1;
    localparam logic [PWMBITS-1:0] ONE     = PWMBITS'(1);
    localparam logic [PSW-1:0]     PS_LAST = PSW'(PRESCALE - 1);

    typedef logic [NCHAN-1:0][PWMBITS-1:0] duty_t;

    logic [PSW-1:0]     presc_q, presc_d;
    logic [PWMBITS-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;   // 1 = counting down (center mode only)
    duty_t              stage_q, stage_d, active_q, active_d, duty_in;
    logic               pending_q, pending_d;
    logic               pstart_q, pstart_d;
    logic [NCHAN-1:0]   vref_q, vref_d;
    logic               tick, boundary;

    // Both operands are zero-extended to PWMBITS so the product cannot truncate.
    always_comb begin
        duty_in = '0;
        for (int i = 0; i < NCHAN; i++) begin
            duty_in[i] = {{MICROSTEPBITS{1'b0}}, current[i*CURRENTBITS +: CURRENTBITS]}
                       * {{CURRENTBITS{1'b0}}, microstep[i*MICROSTEPBITS +: MICROSTEPBITS]};
        end
    end

    assign tick     = (presc_q == PS_LAST);
    assign boundary = enable && tick &&
                      ((CENTER != 0) ? (cnt_q == ONE && dir_q) : (cnt_q == MAX));

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        stage_d   = stage_q;
        active_d  = active_q;
        pending_d = pending_q;
        pstart_d  = boundary;
        vref_d    = '0;

        for (int i = 0; i < NCHAN; i++) begin
            vref_d[i] = enable && (cnt_q < active_q[i]);
        end

        if (!enable) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
        end else if (tick) begin
            presc_d = '0;
            if (CENTER == 0) begin
                cnt_d = cnt_q + ONE;
            end else if (!dir_q) begin
                if (cnt_q == MAX) begin
                    cnt_d = MAX - ONE;
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    dir_d = 1'b0;
                end
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // An update landing on a boundary bypasses staging; otherwise latest update wins.
        if (update) begin
            stage_d = duty_in;
            if (boundary) begin
                active_d  = duty_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (pending_q && (boundary || !enable)) begin
            active_d  = stage_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            stage_q   <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pstart_q  <= 1'b0;
            vref_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            stage_q   <= stage_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pstart_q  <= pstart_d;
            vref_q    <= vref_d;
        end
    end

    assign pending      = pending_q;
    assign period_start = pstart_q;
    assign vref         = vref_q;
endmodule

// File: tb/tb_stepper_vref_pwm.sv
// Bench for stepper_vref_pwm: edge, prescaled-edge and center-aligned instances driven from directed vectors.
module tb_stepper_vref_pwm;
    logic        clk = 1'b0;
    logic        resetn;
    logic        en   [3];
    logic        upd  [3];
    logic [5:0]  cur  [3];
    logic [11:0] ms   [3];
    logic        pend [3];
    logic        pst  [3];
    logic [1:0]  vr   [3];

    int nchk = 0;
    int nerr = 0;
    int per [3] = '{512, 1536, 1022};

    always #5 clk = ~clk;

    stepper_vref_pwm #(.PRESCALE(1), .CENTER(0)) u_edge (
        .clk(clk), .resetn(resetn), .enable(en[0]), .current(cur[0]), .microstep(ms[0]),
        .update(upd[0]), .pending(pend[0]), .period_start(pst[0]), .vref(vr[0]));
    stepper_vref_pwm #(.PRESCALE(3), .CENTER(0)) u_ps3 (
        .clk(clk), .resetn(resetn), .enable(en[1]), .current(cur[1]), .microstep(ms[1]),
        .update(upd[1]), .pending(pend[1]), .period_start(pst[1]), .vref(vr[1]));
    stepper_vref_pwm #(.PRESCALE(1), .CENTER(1)) u_ctr (
        .clk(clk), .resetn(resetn), .enable(en[2]), .current(cur[2]), .microstep(ms[2]),
        .update(upd[2]), .pending(pend[2]), .period_start(pst[2]), .vref(vr[2]));

    typedef struct {
        int         k;
        logic [2:0] c0, c1;
        logic [5:0] m0, m1;
        int         hi0, hi1;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ps(input int k, input string nm);
        int n = 0;
        while (pst[k] !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, pst[k]}, 32'd1);
    endtask

    // Samples one full period starting the cycle after a period start (or enable rise).
    task automatic window(input int k, output int hi0, output int hi1, output int psn,
                          output int pn, output int last_ps);
        hi0 = 0; hi1 = 0; psn = 0; pn = 0; last_ps = 0;
        for (int n = 0; n < per[k]; n++) begin
            @(negedge clk);
            hi0 += int'(vr[k][0]);
            hi1 += int'(vr[k][1]);
            psn += int'(pst[k]);
            pn  += int'(pend[k]);
            last_ps = int'(pst[k]);
        end
    endtask

    task automatic do_update(input int k, input logic [2:0] c0, input logic [5:0] m0,
                             input logic [2:0] c1, input logic [5:0] m1);
        cur[k] = {c1, c0};
        ms[k]  = {m1, m0};
        upd[k] = 1'b1;
        @(negedge clk);
        upd[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0, hi1, psn, pn, lps, n, k;
        vt[0] = '{0, 3'd7, 3'd2, 6'd63, 6'd10, 441, 20};
        vt[1] = '{0, 3'd1, 3'd0, 6'd1,  6'd63, 1,   0};
        vt[2] = '{1, 3'd4, 3'd7, 6'd32, 6'd63, 384, 1323};
        vt[3] = '{1, 3'd0, 3'd1, 6'd5,  6'd1,  0,   3};
        vt[4] = '{2, 3'd2, 3'd7, 6'd10, 6'd63, 39,  881};
        vt[5] = '{2, 3'd1, 3'd0, 6'd1,  6'd0,  1,   0};

        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; upd[i] = 1'b0; cur[i] = '0; ms[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_pend%0d", i), {31'd0, pend[i]}, 32'd0);
            check($sformatf("rst_pst%0d", i),  {31'd0, pst[i]},  32'd0);
            check($sformatf("rst_vref%0d", i), {30'd0, vr[i]},   32'd0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Table: update lands mid-period, waits for the boundary, then one full period is measured.
        for (int v = 0; v < 6; v++) begin
            k = vt[v].k;
            en[k] = 1'b1;
            do_update(k, vt[v].c0, vt[v].m0, vt[v].c1, vt[v].m1);
            check($sformatf("v%0d_pend_set", v), {31'd0, pend[k]}, 32'd1);
            wait_ps(k, $sformatf("v%0d_boundary", v));
            check($sformatf("v%0d_pend_clr", v), {31'd0, pend[k]}, 32'd0);
            window(k, hi0, hi1, psn, pn, lps);
            check($sformatf("v%0d_hi0", v), hi0, vt[v].hi0);
            check($sformatf("v%0d_hi1", v), hi1, vt[v].hi1);
            check($sformatf("v%0d_ps_cnt", v), psn, 1);
            check($sformatf("v%0d_ps_last", v), lps, 1);
        end

        // Update coincident with the boundary goes straight to active.
        @(negedge clk);
        wait_ps(0, "bnd_sync");
        repeat (511) @(negedge clk);
        do_update(0, 3'd1, 6'd1, 3'd1, 6'd1);
        check("bnd_pst", {31'd0, pst[0]}, 32'd1);
        check("bnd_pend", {31'd0, pend[0]}, 32'd0);
        window(0, hi0, hi1, psn, pn, lps);
        check("bnd_hi0", hi0, 1);
        check("bnd_hi1", hi1, 1);
        check("bnd_pend_win", pn, 0);
        check("bnd_ps_last", lps, 1);

        // Enable drop with an update pending.
        repeat (100) @(negedge clk);
        do_update(0, 3'd3, 6'd5, 3'd3, 6'd5);
        check("en_pend_set", {31'd0, pend[0]}, 32'd1);
        en[0] = 1'b0;
        @(negedge clk);
        check("en_vref_low", {30'd0, vr[0]}, 32'd0);
        check("en_pend_clr", {31'd0, pend[0]}, 32'd0);
        repeat (5) @(negedge clk);
        check("en_vref_idle", {30'd0, vr[0]}, 32'd0);
        check("en_pst_idle", {31'd0, pst[0]}, 32'd0);
        en[0] = 1'b1;
        window(0, hi0, hi1, psn, pn, lps);
        check("en_hi0", hi0, 15);
        check("en_hi1", hi1, 15);
        check("en_ps_cnt", psn, 1);
        check("en_ps_last", lps, 1);

        // Prescaled instance: second update before the boundary wins.
        @(negedge clk);
        wait_ps(1, "lw_sync");
        repeat (10) @(negedge clk);
        do_update(1, 3'd4, 6'd32, 3'd1, 6'd1);
        repeat (200) @(negedge clk);
        do_update(1, 3'd0, 6'd32, 3'd1, 6'd2);
        check("lw_pend", {31'd0, pend[1]}, 32'd1);
        wait_ps(1, "lw_boundary");
        check("lw_pend_clr", {31'd0, pend[1]}, 32'd0);
        window(1, hi0, hi1, psn, pn, lps);
        check("lw_hi0", hi0, 0);
        check("lw_hi1", hi1, 6);

        // Asynchronous reset mid-period with an update pending.
        @(negedge clk);
        wait_ps(0, "rst_sync");
        do_update(0, 3'd7, 6'd63, 3'd7, 6'd63);
        check("mrst_pend_pre", {31'd0, pend[0]}, 32'd1);
        check("mrst_vref_pre", {30'd0, vr[0]}, 32'd3);
        #2 resetn = 1'b0;
        #1;
        check("mrst_pend", {31'd0, pend[0]}, 32'd0);
        check("mrst_vref", {30'd0, vr[0]}, 32'd0);
        check("mrst_pst", {31'd0, pst[0]}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        hi0 = 0;
        while (pst[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            hi0 += int'(vr[0][0]) + int'(vr[0][1]);
        end
        check("mrst_first_ps", n, 512);
        check("mrst_vref_cnt", hi0, 0);
        check("mrst_pend_after", {31'd0, pend[0]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/stepper_vref_pwm.md
# stepper_vref_pwm

Multi-channel, parametrised PWM reference generator for stepper coil current (Vref) in the motor-control datapath. Each channel takes a current-limit code and a microstep amplitude and fuses them into a single PWM duty (current × amplitude) with no truncation. New settings are double-buffered and take effect only at a PWM period boundary, so the waveform never glitches mid-period. Edge-aligned and center-aligned modes are selectable, with a clock prescaler for placing the PWM frequency above the audible band.

## Interface
- NCHAN, 2, number of independent Vref channels (coils)
- CURRENTBITS, 3, width of each current-limit code
- MICROSTEPBITS, 6, width of each microstep amplitude code
- PRESCALE, 1, clocks per PWM counter tick (≥1)
- CENTER, 0, 0 = edge-aligned counter, 1 = center-aligned up/down counter
- Derived: PWMBITS = CURRENTBITS+MICROSTEPBITS; MAX = 2^PWMBITS−1
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  run PWM; low forces all vref low and parks the counter
- current  in  NCHAN*CURRENTBITS  per-channel current code, channel i at [i*CURRENTBITS +: CURRENTBITS]
- microstep  in  NCHAN*MICROSTEPBITS  per-channel amplitude, packed the same way
- update  in  1  one-cycle strobe; captures all current/microstep lanes into staging
- pending  out  1  staging holds values not yet applied
- period_start  out  1  one-cycle pulse when a new PWM period begins
- vref  out  NCHAN  registered PWM outputs

## Operation
- Reset (async, resetn low): prescaler=0, cnt=0, dir=up, staging=0, active duty=0, pending=0, period_start=0, vref=0.
- Duty: D[i] = current[i] × microstep[i], unsigned, PWMBITS wide (max (2^C−1)(2^M−1) < 2^PWMBITS, no overflow). Compute at capture and store D in staging.
- Prescaler counts 0..PRESCALE−1. tick = (prescaler == PRESCALE−1). PRESCALE=1 gives a tick every cycle.
- Edge mode: on tick, cnt increments and wraps MAX→0. Boundary = tick with cnt==MAX.
- Center mode: on tick, cnt counts up 0→MAX, then down MAX−1→1, then 0 again. dir flips at MAX and at 0. Period is 2·MAX ticks. Boundary = tick with cnt==1 and dir==down.
- Compare: vref[i] <= enable & (cnt < active[i]), registered. D=0 gives a constant low. Full-scale high is unreachable by design.
- Staging: update captures D for every channel into staging and sets pending=1. A second update while pending overwrites staging (latest wins).
- Transfer: on a boundary with pending=1, staging→active and pending clears.
- update coincident with a boundary: the newly captured values go straight to active and pending stays 0.
- period_start is registered high for the one cycle in which cnt==0 begins a new period after a boundary. It is not asserted on the first period after reset or after enable rises.
- enable low: prescaler=0, cnt=0, dir=up, vref=0 from the next cycle. update is still accepted, and any pending staging transfers to active on the following cycle (pending→0). On enable rising, counting starts from cnt=0 with the current active duties.
- A mid-operation reset abandons the period immediately. All state returns to reset values, including staging.

## Timing
- vref latency: 1 clk from the cnt/active state to the pin.
- Edge mode high time per period = D·PRESCALE clocks. Period = 2^PWMBITS·PRESCALE clocks.
- Center mode high time per period = (2D−1)·PRESCALE clocks for D≥1, 0 for D=0. Period = 2·MAX·PRESCALE clocks.
- Update-to-effect is at most one full period plus 1 clk. pending falls in the same cycle active loads.
- period_start and the first cycle of new-duty comparison coincide. vref shows the new duty 1 clk later.
- Sizing: 16 MHz clock with PWMBITS=9 and PRESCALE=1 gives ≈31 kHz edge-mode PWM.

## Test plan
- Reset mid-period with resetn low for 3 clk -> vref=0, pending=0, period_start=0 immediately (async); counting restarts from cnt=0 after release.
- Defaults, edge mode, enable=1, update current=7, microstep=63 -> pending until first boundary; then vref high exactly 441 of every 512 clk; period_start every 512 clk.
- current=4, microstep=32, PRESCALE=3 -> 128×3=384 high of 1536 clk per period; a second update (current=0) mid-period -> no change until boundary, then vref constantly low.
- CENTER=1, current=2, microstep=10 (D=20) -> high 39 of 1022 clk per period, centered on cnt=0; period_start each 1022 clk.
- update asserted in the boundary cycle with current=1, microstep=1 -> pending never rises; next period vref high 1 clk.
- enable dropped mid-period with an update pending -> vref low next clk, pending clears next clk; enable raised -> counting resumes at cnt=0 with the new duty and no period_start for that first period.
